dmem_arbiter: RTL and testbench

- Arbitrates one single-port memory bus between two requesters: instruction fetch (IF) and the MEM-stage data port (DM).
- Sequences each access as a registered request/ack transaction, so the memory may have variable latency.
- Raises stall_req toward the pipeline controller while any requester is waiting.
- Sits between the MEM stage / IF stage and the shared memory model or SRAM.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arb_wdog.sv | 28 ++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data/instruction memory arbiter: FSM states and common constants.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY_DM = 2'b01,
        ARB_BUSY_IF = 2'b10
    } arb_state_t;

    localparam logic        ENABLE   = 1'b1;
    localparam logic        DISABLE  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/dmem_arb_wdog.sv
// Busy-cycle watchdog for dmem_arbiter; built only when DMEM_ARB_TIMEOUT_EN is defined.
module dmem_arb_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_busy,
    input  logic i_ack,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_busy && !i_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th busy cycle without ack; an ack in that cycle wins.
    assign o_expire = i_busy && !i_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority (DM over IF) arbiter for one shared memory bus with request/ack handshake.
// Optional busy-state timeout enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rddata,
    output logic              if_ready,
    input  logic              dm_ce,
    input  logic              dm_wrn,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wrdata,
    output logic [DATA_W-1:0] dm_rddata,
    output logic              dm_ready,
    output logic              bus_ce,
    output logic              bus_wrn,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wrdata,
    input  logic [DATA_W-1:0] bus_rddata,
    input  logic              bus_ack,
    output logic              stall_req,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds x_ce high until the single-cycle x_ready pulse;
    // the memory sees bus_ce held stable until it returns a one-cycle bus_ack.

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              w_grant_dm;
    logic              w_grant_if;
    logic              w_done;
    logic              w_timeout;
    logic              r_bus_ce;
    logic              r_bus_wrn;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wrdata;
    logic [DATA_W-1:0] r_if_rddata;
    logic [DATA_W-1:0] r_dm_rddata;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic              w_busy;

    assign w_busy = (r_state == ARB_BUSY_DM) || (r_state == ARB_BUSY_IF);

`ifdef DMEM_ARB_TIMEOUT_EN
    logic r_bus_err;

    dmem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_grant_dm || w_grant_if),
        .i_busy   (w_busy),
        .i_ack    (bus_ack),
        .o_expire (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err <= DISABLE;
        end else begin
            r_bus_err <= w_done && !bus_ack;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_cfg;

    assign w_timeout    = DISABLE;
    assign bus_err      = DISABLE;
    assign w_unused_cfg = w_busy ^ TIMEOUT[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_dm = DISABLE;
        w_grant_if = DISABLE;
        w_done     = DISABLE;
        case (r_state)
            ARB_IDLE: begin
                if (dm_ce) begin
                    w_next     = ARB_BUSY_DM;
                    w_grant_dm = ENABLE;
                end else if (if_ce) begin
                    w_next     = ARB_BUSY_IF;
                    w_grant_if = ENABLE;
                end
            end
            ARB_BUSY_DM, ARB_BUSY_IF: begin
                if (bus_ack || w_timeout) begin
                    w_next = ARB_IDLE;
                    w_done = ENABLE;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_ce     <= DISABLE;
            r_bus_wrn    <= DISABLE;
            r_bus_addr   <= '0;
            r_bus_wrdata <= DATA_W'(ZeroWord);
            r_if_rddata  <= DATA_W'(ZeroWord);
            r_dm_rddata  <= DATA_W'(ZeroWord);
            r_if_ready   <= DISABLE;
            r_dm_ready   <= DISABLE;
        end else begin
            r_if_ready <= DISABLE;
            r_dm_ready <= DISABLE;
            if (w_grant_dm) begin
                r_bus_ce     <= ENABLE;
                r_bus_wrn    <= dm_wrn;
                r_bus_addr   <= dm_addr;
                r_bus_wrdata <= dm_wrn ? dm_wrdata : DATA_W'(ZeroWord);
            end else if (w_grant_if) begin
                r_bus_ce     <= ENABLE;
                r_bus_wrn    <= DISABLE;
                r_bus_addr   <= if_addr;
                r_bus_wrdata <= DATA_W'(ZeroWord);
            end else if (w_done) begin
                r_bus_ce <= DISABLE;
                // Writes and aborted accesses return a zero word.
                if (r_state == ARB_BUSY_DM) begin
                    r_dm_ready  <= ENABLE;
                    r_dm_rddata <= (bus_ack && !r_bus_wrn) ? bus_rddata : DATA_W'(ZeroWord);
                end else begin
                    r_if_ready  <= ENABLE;
                    r_if_rddata <= bus_ack ? bus_rddata : DATA_W'(ZeroWord);
                end
            end
        end
    end

    assign bus_ce     = r_bus_ce;
    assign bus_wrn    = r_bus_wrn;
    assign bus_addr   = r_bus_addr;
    assign bus_wrdata = r_bus_wrdata;
    assign if_rddata  = r_if_rddata;
    assign if_ready   = r_if_ready;
    assign dm_rddata  = r_dm_rddata;
    assign dm_ready   = r_dm_ready;
    assign stall_req  = (if_ce && !r_if_ready) || (dm_ce && !r_dm_ready);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_ce;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rddata;
    logic              if_ready;
    logic              dm_ce;
    logic              dm_wrn;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wrdata;
    logic [DATA_W-1:0] dm_rddata;
    logic              dm_ready;
    logic              bus_ce;
    logic              bus_wrn;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wrdata;
    logic [DATA_W-1:0] bus_rddata;
    logic              bus_ack;
    logic              stall_req;
    logic              bus_err;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_ce      (if_ce),
        .if_addr    (if_addr),
        .if_rddata  (if_rddata),
        .if_ready   (if_ready),
        .dm_ce      (dm_ce),
        .dm_wrn     (dm_wrn),
        .dm_addr    (dm_addr),
        .dm_wrdata  (dm_wrdata),
        .dm_rddata  (dm_rddata),
        .dm_ready   (dm_ready),
        .bus_ce     (bus_ce),
        .bus_wrn    (bus_wrn),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_rddata (bus_rddata),
        .bus_ack    (bus_ack),
        .stall_req  (stall_req),
        .bus_err    (bus_err),
        .dbg_state  (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        if_ce      = 1'b0;
        if_addr    = '0;
        dm_ce      = 1'b0;
        dm_wrn     = 1'b0;
        dm_addr    = '0;
        dm_wrdata  = '0;
        bus_rddata = '0;
        bus_ack    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_bus_ce", 32'(bus_ce), 32'h0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_dm_ready", 32'(dm_ready), 32'h0);
        check_eq("rst_if_ready", 32'(if_ready), 32'h0);
        check_eq("rst_bus_err", 32'(bus_err), 32'h0);
        check_eq("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        check_eq("rst_stall", 32'(stall_req), 32'h0);

        // DM read, ack on first busy cycle
        dm_ce = 1'b1; dm_wrn = 1'b0; dm_addr = 32'h10;
        #1;
        check_eq("rd_stall_req", 32'(stall_req), 32'h1);
        tick();
        check_eq("rd_bus_ce", 32'(bus_ce), 32'h1);
        check_eq("rd_bus_addr", bus_addr, 32'h10);
        check_eq("rd_bus_wrn", 32'(bus_wrn), 32'h0);
        check_eq("rd_state", 32'(dbg_state), 32'(ARB_BUSY_DM));
        check_eq("rd_stall_busy", 32'(stall_req), 32'h1);
        bus_ack = 1'b1; bus_rddata = 32'h1234_5678;
        tick();
        check_eq("rd_dm_ready", 32'(dm_ready), 32'h1);
        check_eq("rd_dm_rddata", dm_rddata, 32'h1234_5678);
        check_eq("rd_bus_ce_off", 32'(bus_ce), 32'h0);
        check_eq("rd_stall_done", 32'(stall_req), 32'h0);
        dm_ce = 1'b0; bus_ack = 1'b0; bus_rddata = 32'h0;
        tick();
        check_eq("rd_ready_pulse", 32'(dm_ready), 32'h0);
        check_eq("rd_rddata_hold", dm_rddata, 32'h1234_5678);

        // DM write with a 3-cycle ack delay; address change while busy is ignored
        dm_ce = 1'b1; dm_wrn = 1'b1; dm_addr = 32'h20; dm_wrdata = 32'hDEAD_BEEF;
        tick();
        dm_addr = 32'h99; dm_wrdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            check_eq("wr_bus_ce", 32'(bus_ce), 32'h1);
            check_eq("wr_bus_wrn", 32'(bus_wrn), 32'h1);
            check_eq("wr_bus_addr", bus_addr, 32'h20);
            check_eq("wr_bus_wrdata", bus_wrdata, 32'hDEAD_BEEF);
            check_eq("wr_no_ready", 32'(dm_ready), 32'h0);
            if (i == 2) begin
                bus_ack = 1'b1; bus_rddata = 32'hAAAA_AAAA;
            end
            tick();
        end
        check_eq("wr_dm_ready", 32'(dm_ready), 32'h1);
        check_eq("wr_dm_rddata", dm_rddata, 32'h0);
        check_eq("wr_bus_ce_off", 32'(bus_ce), 32'h0);
        dm_ce = 1'b0; dm_wrn = 1'b0; bus_ack = 1'b0;

        // Simultaneous DM and IF requests
        dm_ce = 1'b1; dm_addr = 32'h30; if_ce = 1'b1; if_addr = 32'h40;
        tick();
        check_eq("pri_state_dm", 32'(dbg_state), 32'(ARB_BUSY_DM));
        check_eq("pri_bus_addr", bus_addr, 32'h30);
        check_eq("pri_stall1", 32'(stall_req), 32'h1);
        bus_ack = 1'b1; bus_rddata = 32'h1111_1111;
        tick();
        check_eq("pri_dm_ready", 32'(dm_ready), 32'h1);
        check_eq("pri_dm_rddata", dm_rddata, 32'h1111_1111);
        check_eq("pri_if_wait", 32'(if_ready), 32'h0);
        check_eq("pri_stall2", 32'(stall_req), 32'h1);
        dm_ce = 1'b0; bus_ack = 1'b0;
        tick();
        check_eq("pri_state_if", 32'(dbg_state), 32'(ARB_BUSY_IF));
        check_eq("pri_if_addr", bus_addr, 32'h40);
        check_eq("pri_if_wrn", 32'(bus_wrn), 32'h0);
        check_eq("pri_stall3", 32'(stall_req), 32'h1);
        bus_ack = 1'b1; bus_rddata = 32'h2222_2222;
        tick();
        check_eq("pri_if_ready", 32'(if_ready), 32'h1);
        check_eq("pri_if_rddata", if_rddata, 32'h2222_2222);
        check_eq("pri_stall_done", 32'(stall_req), 32'h0);
        check_eq("pri_dm_hold", dm_rddata, 32'h1111_1111);
        if_ce = 1'b0; bus_ack = 1'b0;
        tick();

`ifdef DMEM_ARB_TIMEOUT_EN
        // No ack ever: abort after 15 busy cycles
        dm_ce = 1'b1; dm_wrn = 1'b0; dm_addr = 32'h60;
        tick();
        for (int i = 0; i < 15; i++) begin
            check_eq("to_bus_ce", 32'(bus_ce), 32'h1);
            check_eq("to_no_err", 32'(bus_err), 32'h0);
            tick();
        end
        check_eq("to_bus_err", 32'(bus_err), 32'h1);
        check_eq("to_dm_ready", 32'(dm_ready), 32'h1);
        check_eq("to_dm_rddata", dm_rddata, 32'h0);
        check_eq("to_bus_ce_off", 32'(bus_ce), 32'h0);
        dm_ce = 1'b0;
        tick();
        check_eq("to_err_pulse", 32'(bus_err), 32'h0);
        dm_ce = 1'b1; dm_addr = 32'h64;
        tick();
        check_eq("to_regrant", 32'(bus_ce), 32'h1);
        check_eq("to_regrant_addr", bus_addr, 32'h64);
        bus_ack = 1'b1; bus_rddata = 32'h7777_0000;
        tick();
        check_eq("to_regrant_data", dm_rddata, 32'h7777_0000);
        check_eq("to_regrant_err", 32'(bus_err), 32'h0);
        dm_ce = 1'b0; bus_ack = 1'b0;
        tick();
`endif

        // Reset during BUSY_IF, then a late ack
        if_ce = 1'b1; if_addr = 32'h50;
        tick();
        check_eq("rs_state_if", 32'(dbg_state), 32'(ARB_BUSY_IF));
        rst = 1'b1;
        tick();
        check_eq("rs_bus_ce", 32'(bus_ce), 32'h0);
        check_eq("rs_state", 32'(dbg_state), 32'(ARB_IDLE));
        check_eq("rs_if_ready", 32'(if_ready), 32'h0);
        rst = 1'b0; if_ce = 1'b0; bus_ack = 1'b1; bus_rddata = 32'h3333_3333;
        tick();
        check_eq("rs_ack_ready", 32'(if_ready), 32'h0);
        check_eq("rs_ack_rddata", if_rddata, 32'h0);
        check_eq("rs_ack_state", 32'(dbg_state), 32'(ARB_IDLE));

        // Spurious ack while idle
        bus_rddata = 32'hFFFF_FFFF;
        tick();
        check_eq("sp_bus_ce", 32'(bus_ce), 32'h0);
        check_eq("sp_dm_ready", 32'(dm_ready), 32'h0);
        check_eq("sp_if_ready", 32'(if_ready), 32'h0);
        check_eq("sp_dm_rddata", dm_rddata, 32'h0);
        check_eq("sp_bus_err", 32'(bus_err), 32'h0);
        bus_ack = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
